data_rate_switch_ctrl: RTL and testbench

Controller that owns the `dataRate` select of the serializer-side data extender and switches it safely at run time. A rate request is sampled, held until the next frame boundary, then applied together with a guard burst of idle words so the receiver never sees a word formatted at a mixed rate. The block sits between the slow-control register bank and the data packer/extender. It registers both the rate select and the 32-bit word that feeds the extender.

---
 rtl/data_rate_switch_ctrl_if.sv | 34 +++
 rtl/data_rate_switch_ctrl.sv | 109 ++++++++++
 tb/tb_data_rate_switch_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_rate_switch_ctrl_if.sv
// data_rate_switch_ctrl_if
// Bundles the rate-request handshake, the packer data path and the status
// outputs of data_rate_switch_ctrl.
//   master : slow-control / packer side (drives requests, frameStart, din)
//   slave  : the controller (drives dataRate, dout and the status flags)
// Signals:
//   rateReq[1:0], rateReqValid : requested rate and its one-cycle strobe
//   frameStart                 : first word of a frame, from the packer
//   din[31:0]                  : packed word from the packer
//   dataRate[1:0], dout[31:0]  : registered rate select and word to the extender
//   rateBusy, rateAck, rateErr : switch in progress / done / rejected
//   switchCount[7:0]           : saturating count of completed rate changes
interface data_rate_switch_ctrl_if;
  logic [1:0]  rateReq;
  logic        rateReqValid;
  logic        frameStart;
  logic [31:0] din;
  logic [1:0]  dataRate;
  logic [31:0] dout;
  logic        rateBusy;
  logic        rateAck;
  logic        rateErr;
  logic [7:0]  switchCount;

  modport master (
    output rateReq, rateReqValid, frameStart, din,
    input  dataRate, dout, rateBusy, rateAck, rateErr, switchCount
  );

  modport slave (
    input  rateReq, rateReqValid, frameStart, din,
    output dataRate, dout, rateBusy, rateAck, rateErr, switchCount
  );
endinterface

// File: rtl/data_rate_switch_ctrl.sv
// data_rate_switch_ctrl
// Owns the dataRate select of the serializer-side data extender. A rate
// request is held until the next frame boundary, then applied together with
// a burst of GUARD_WORDS idle words so no word is formatted at a mixed rate.
// Ports:
//   clk40 : 40 MHz word clock, rising edge
//   reset : asynchronous, active-high
//   bus   : data_rate_switch_ctrl_if.slave (requests, data path, status)
//
// state  | meaning
// RUN    | normal pass-through, accepting rate requests
// ARM    | request pending, waiting for a frameStart (with timeout)
// GUARD  | new rate applied, emitting the idle-word burst
module data_rate_switch_ctrl #(
  parameter logic [1:0]  DEFAULT_RATE = 2'b00,
  parameter logic [31:0] IDLE_WORD    = 32'h3C5C_3C5C,
  parameter int unsigned GUARD_WORDS  = 4,
  parameter int unsigned ARM_TIMEOUT  = 255
) (
  input logic                   clk40,
  input logic                   reset,
  data_rate_switch_ctrl_if.slave bus
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;

  localparam logic [7:0] GUARD_LOAD   = 8'(GUARD_WORDS - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(ARM_TIMEOUT - 1);

  logic [1:0]  state;
  logic [1:0]  pend_rate;
  logic [7:0]  tmo_cnt;
  logic [7:0]  guard_cnt;
  logic [1:0]  data_rate;
  logic [31:0] dout_q;
  logic        ack_q;
  logic        err_q;
  logic [7:0]  sw_cnt;

  always_ff @(posedge clk40 or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      pend_rate <= 2'b00;
      tmo_cnt   <= 8'd0;
      guard_cnt <= 8'd0;
      data_rate <= DEFAULT_RATE;
      dout_q    <= 32'd0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      sw_cnt    <= 8'd0;
    end else begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      dout_q <= bus.din;
      case (state)
        ST_RUN: begin
          if (bus.rateReqValid) begin
            if (bus.rateReq == 2'b11) begin
              err_q <= 1'b1;
            end else if (bus.rateReq == data_rate) begin
              ack_q <= 1'b1;
            end else begin
              pend_rate <= bus.rateReq;
              tmo_cnt   <= 8'd0;
              state     <= ST_ARM;
            end
          end
        end
        ST_ARM: begin
          // A request while busy is dropped; the pending switch carries on.
          if (bus.rateReqValid) err_q <= 1'b1;
          if (bus.frameStart) begin
            data_rate <= pend_rate;
            dout_q    <= IDLE_WORD;
            guard_cnt <= GUARD_LOAD;
            state     <= ST_GUARD;
          end else if (tmo_cnt == TIMEOUT_LAST) begin
            err_q <= 1'b1;
            state <= ST_RUN;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        ST_GUARD: begin
          if (bus.rateReqValid) err_q <= 1'b1;
          if (guard_cnt != 8'd0) begin
            dout_q    <= IDLE_WORD;
            guard_cnt <= guard_cnt - 8'd1;
          end else begin
            ack_q <= 1'b1;
            if (sw_cnt != 8'hFF) sw_cnt <= sw_cnt + 8'd1;
            state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign bus.dataRate    = data_rate;
  assign bus.dout        = dout_q;
  assign bus.rateBusy    = (state != ST_RUN);
  assign bus.rateAck     = ack_q;
  assign bus.rateErr     = err_q;
  assign bus.switchCount = sw_cnt;

endmodule

// File: tb/tb_data_rate_switch_ctrl.sv
// tb_data_rate_switch_ctrl
// Scenario bench for data_rate_switch_ctrl (default parameters). Each
// scenario pushes the expected outputs for a cycle when it drives that
// cycle's stimulus, then pops and compares once the DUT has registered it.
module tb_data_rate_switch_ctrl;

  localparam logic [31:0] IDLE = 32'h3C5C_3C5C;
  localparam int          G    = 4;
  localparam int          TMO  = 255;

  typedef struct packed {
    logic [31:0] dout;
    logic [1:0]  rate;
    logic        busy;
    logic        ack;
    logic        err;
    logic [7:0]  cnt;
  } obs_t;

  logic clk40;
  logic reset;
  data_rate_switch_ctrl_if bus();

  data_rate_switch_ctrl dut (
    .clk40 (clk40),
    .reset (reset),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t sb[$];
  logic [1:0] cur_rate;
  logic [7:0] cur_cnt;

  initial clk40 = 1'b0;
  always #5 clk40 = ~clk40;

  function automatic obs_t observe();
    obs_t o;
    o.dout = bus.dout;
    o.rate = bus.dataRate;
    o.busy = bus.rateBusy;
    o.ack  = bus.rateAck;
    o.err  = bus.rateErr;
    o.cnt  = bus.switchCount;
    return o;
  endfunction

  task automatic drive(input logic [1:0] req, input logic v, input logic fs,
                       input logic [31:0] d);
    bus.rateReq      = req;
    bus.rateReqValid = v;
    bus.frameStart   = fs;
    bus.din          = d;
  endtask

  task automatic tick();
    @(posedge clk40);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk40);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    cur_rate = 2'b00;
    cur_cnt  = 8'd0;
  endtask

  task automatic test_reset();
    obs_t e, a;
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    repeat (3) @(posedge clk40);
    #1;
    e = '0;
    a = observe();
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL reset_values actual=%h required=%h", a, e);
    end
    @(negedge clk40);
    reset = 1'b0;
    cur_rate = 2'b00;
    cur_cnt  = 8'd0;
    drive(2'b00, 1'b0, 1'b0, 32'hA5A5_0001);
    e = '0;
    e.dout = 32'hA5A5_0001;
    sb.push_back(e);
    tick();
    e = sb.pop_front();
    a = observe();
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL reset_passthru actual=%h required=%h", a, e);
    end
  endtask

  task automatic test_same_and_illegal();
    obs_t e, a;
    logic [31:0] d;
    for (int c = 0; c < 6; c++) begin
      d = $urandom;
      case (c)
        0:       drive(2'b00, 1'b1, 1'b0, d);
        2:       drive(2'b11, 1'b1, 1'b0, d);
        3:       drive(2'b01, 1'b0, 1'b1, d);
        default: drive(2'b00, 1'b0, 1'b0, d);
      endcase
      e.dout = d;
      e.rate = cur_rate;
      e.busy = 1'b0;
      e.ack  = (c == 0);
      e.err  = (c == 2);
      e.cnt  = cur_cnt;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      a = observe();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL same_illegal c=%0d actual=%h required=%h", c, a, e);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t e, a;
    logic [31:0] d;
    // frameStart alongside the request must not be taken as the boundary
    for (int c = 0; c < TMO + 5; c++) begin
      d = $urandom;
      drive(2'b01, c == 0, c == 0, d);
      e.dout = d;
      e.rate = cur_rate;
      e.busy = (c <= TMO - 1);
      e.ack  = 1'b0;
      e.err  = (c == TMO);
      e.cnt  = cur_cnt;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      a = observe();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL timeout c=%0d actual=%h required=%h", c, a, e);
      end
    end
  endtask

  task automatic test_switch();
    obs_t e, a;
    logic [31:0] d;
    // request at 0, boundary at 5, stray frameStart at 7 during the burst
    for (int c = 0; c < 14; c++) begin
      d = $urandom;
      drive(2'b10, c == 0, (c == 5) || (c == 7), d);
      e.dout = (c >= 5 && c <= 5 + G - 1) ? IDLE : d;
      e.rate = (c >= 5) ? 2'b10 : cur_rate;
      e.busy = (c <= 5 + G - 1);
      e.ack  = (c == 5 + G);
      e.err  = 1'b0;
      e.cnt  = (c >= 5 + G) ? cur_cnt + 8'd1 : cur_cnt;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      a = observe();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL switch c=%0d actual=%h required=%h", c, a, e);
      end
    end
    cur_rate = 2'b10;
    cur_cnt  = cur_cnt + 8'd1;
  endtask

  task automatic test_drop_in_guard();
    obs_t e, a;
    logic [31:0] d;
    pulse_reset();
    for (int c = 0; c < 10; c++) begin
      d = $urandom;
      if (c == 4) drive(2'b01, 1'b1, 1'b0, d);
      else        drive(2'b10, c == 0, c == 2, d);
      e.dout = (c >= 2 && c <= 2 + G - 1) ? IDLE : d;
      e.rate = (c >= 2) ? 2'b10 : 2'b00;
      e.busy = (c <= 2 + G - 1);
      e.ack  = (c == 2 + G);
      e.err  = (c == 4);
      e.cnt  = (c >= 2 + G) ? 8'd1 : 8'd0;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      a = observe();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL drop_in_guard c=%0d actual=%h required=%h", c, a, e);
      end
    end
    cur_rate = 2'b10;
    cur_cnt  = 8'd1;
  endtask

  task automatic test_reset_mid_guard();
    obs_t e, a;
    logic [31:0] d;
    // 10 -> 01, boundary at 1; after c=2 the DUT is in its second guard cycle
    for (int c = 0; c < 3; c++) begin
      d = $urandom;
      drive(2'b01, c == 0, c == 1, d);
      e.dout = (c >= 1) ? IDLE : d;
      e.rate = (c >= 1) ? 2'b01 : cur_rate;
      e.busy = 1'b1;
      e.ack  = 1'b0;
      e.err  = 1'b0;
      e.cnt  = cur_cnt;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      a = observe();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL mid_guard_pre c=%0d actual=%h required=%h", c, a, e);
      end
    end
    reset = 1'b1;
    #1;
    e = '0;
    a = observe();
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL mid_guard_async_reset actual=%h required=%h", a, e);
    end
    #1;
    reset = 1'b0;
    cur_rate = 2'b00;
    cur_cnt  = 8'd0;
    for (int c = 0; c < 8; c++) begin
      d = $urandom;
      drive(2'b00, 1'b0, 1'b0, d);
      e.dout = d;
      e.rate = 2'b00;
      e.busy = 1'b0;
      e.ack  = 1'b0;
      e.err  = 1'b0;
      e.cnt  = 8'd0;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      a = observe();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL mid_guard_post c=%0d actual=%h required=%h", c, a, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, a;
    logic [31:0] d;
    logic [1:0]  nr;
    int          done;
    pulse_reset();
    for (int k = 0; k < 300; k++) begin
      nr = (k % 2 == 0) ? 2'b01 : 2'b10;
      for (int c = 0; c < G + 2; c++) begin
        d = $urandom;
        drive(nr, c == 0, c == 1, d);
        done   = (c == G + 1) ? k + 1 : k;
        e.dout = (c >= 1 && c <= G) ? IDLE : d;
        e.rate = (c >= 1) ? nr : cur_rate;
        e.busy = (c <= G);
        e.ack  = (c == G + 1);
        e.err  = 1'b0;
        e.cnt  = (done > 255) ? 8'd255 : 8'(done);
        sb.push_back(e);
        tick();
        e = sb.pop_front();
        a = observe();
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL back_to_back k=%0d c=%0d actual=%h required=%h", k, c, a, e);
        end
      end
      cur_rate = nr;
    end
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    tick();
    n_checks++;
    if (bus.switchCount !== 8'd255) begin
      n_fail++;
      $display("FAIL saturation actual=%0d required=255", bus.switchCount);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_same_and_illegal();
    test_timeout();
    test_switch();
    test_drop_in_guard();
    test_reset_mid_guard();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
